// File: rtl/led7_pkg.sv
// Shared constants for the seven-segment display path.
// All segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package led7_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_NONE   = 8'hFF;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble-to-segment decoder; every nibble value has a glyph.
module hex_to_7seg
    import led7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
        endcase
    end

endmodule

// File: rtl/led7_display.sv
// Registered hex-to-seven-segment driver for common-anode displays.
// One cycle of latency; reset blanks segments and anodes immediately.
module led7_display
    import led7_pkg::*;
(
    input  logic       i_w_clk,
    input  logic       i_w_rst_n,
    input  logic [3:0] i_w_in,
    input  logic [7:0] i_w_an,
    output logic [6:0] o_w_7seg,
    output logic [7:0] o_w_an
);

    logic [6:0] seg_dec;
    logic [6:0] seg_p0;
    logic [7:0] an_p0;

    hex_to_7seg u_dec (
        .hex (i_w_in),
        .seg (seg_dec)
    );

    // Output register stage: the pins see only flop outputs, never the decoder.
    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            seg_p0 <= SEG_BLANK;
            an_p0  <= AN_NONE;
        end else begin
            seg_p0 <= seg_dec;
            an_p0  <= i_w_an;
        end
    end

    assign o_w_7seg = seg_p0;
    assign o_w_an   = an_p0;

endmodule

// File: tb/tb_led7_display.sv
// Self-checking bench for led7_display: vector table through a scoreboard,
// plus hand-written reset and latency sequences.
module tb_led7_display;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_v;
    logic [7:0] an_v;
    logic [6:0] seg_o;
    logic [7:0] an_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] in;
        logic [7:0] an;
        logic [6:0] seg_exp;
        logic [7:0] an_exp;
    } vec_t;

    typedef struct packed {
        logic [6:0] seg;
        logic [7:0] an;
    } exp_t;

    vec_t vecs [20];
    exp_t sb [$];
    exp_t e;

    led7_display dut (
        .i_w_clk   (clk),
        .i_w_rst_n (rst_n),
        .i_w_in    (in_v),
        .i_w_an    (an_v),
        .o_w_7seg  (seg_o),
        .o_w_an    (an_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{4'h0, 8'hFE, 7'd64,  8'hFE};
        vecs[1]  = '{4'h1, 8'hFE, 7'd121, 8'hFE};
        vecs[2]  = '{4'h2, 8'hFE, 7'd36,  8'hFE};
        vecs[3]  = '{4'h3, 8'hFE, 7'd48,  8'hFE};
        vecs[4]  = '{4'h4, 8'hFE, 7'd25,  8'hFE};
        vecs[5]  = '{4'h5, 8'hFE, 7'd18,  8'hFE};
        vecs[6]  = '{4'h6, 8'hFE, 7'd2,   8'hFE};
        vecs[7]  = '{4'h7, 8'hFE, 7'd120, 8'hFE};
        vecs[8]  = '{4'h8, 8'hFE, 7'd0,   8'hFE};
        vecs[9]  = '{4'h9, 8'hFE, 7'd16,  8'hFE};
        vecs[10] = '{4'hA, 8'hFE, 7'h08,  8'hFE};
        vecs[11] = '{4'hB, 8'hFE, 7'h03,  8'hFE};
        vecs[12] = '{4'hC, 8'hFE, 7'h46,  8'hFE};
        vecs[13] = '{4'hD, 8'hFE, 7'h21,  8'hFE};
        vecs[14] = '{4'hE, 8'hFE, 7'h06,  8'hFE};
        vecs[15] = '{4'hF, 8'hFE, 7'h0E,  8'hFE};
        vecs[16] = '{4'h8, 8'h7F, 7'h00,  8'h7F};
        vecs[17] = '{4'h3, 8'hBF, 7'h30,  8'hBF};
        vecs[18] = '{4'hC, 8'h00, 7'h46,  8'h00};
        vecs[19] = '{4'hF, 8'hFF, 7'h0E,  8'hFF};

        // Async reset with no clock edge yet (first rising edge is at t=5).
        rst_n = 1'b1;
        in_v  = 4'h8;
        an_v  = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_seg_async", {1'b0, seg_o}, 8'h7F);
        check("reset_an_async", an_o, 8'hFF);

        // Reset must hold against clock edges.
        repeat (2) @(posedge clk);
        #1;
        check("reset_seg_held", {1'b0, seg_o}, 8'h7F);
        check("reset_an_held", an_o, 8'hFF);

        // Release between edges; the next edge loads decoded values.
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: back-to-back, one new input each cycle.
        for (int i = 0; i < 20; i++) begin
            in_v = vecs[i].in;
            an_v = vecs[i].an;
            sb.push_back('{vecs[i].seg_exp, vecs[i].an_exp});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d_seg", i), {1'b0, seg_o}, {1'b0, e.seg});
            check($sformatf("vec%0d_an", i), an_o, e.an);
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        // Latency: change input just after an edge, output waits for next edge.
        an_v = 8'hFE;
        in_v = 4'h1;
        @(posedge clk);
        #1;
        in_v = 4'h7;
        #2;
        check("latency_hold_early", {1'b0, seg_o}, 8'h79);
        @(negedge clk);
        check("latency_hold_mid", {1'b0, seg_o}, 8'h79);
        @(posedge clk);
        #1;
        check("latency_update", {1'b0, seg_o}, 8'h78);

        // Mid-operation reset while showing 0.
        in_v = 4'h0;
        an_v = 8'hFE;
        @(posedge clk);
        #1;
        check("pre_reset_seg", {1'b0, seg_o}, 8'h40);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_seg", {1'b0, seg_o}, 8'h7F);
        check("midreset_an", an_o, 8'hFF);
        #1;
        rst_n = 1'b1;
        #1;
        check("midreset_release_wait_seg", {1'b0, seg_o}, 8'h7F);
        check("midreset_release_wait_an", an_o, 8'hFF);
        @(posedge clk);
        #1;
        check("post_reset_seg", {1'b0, seg_o}, 8'h40);
        check("post_reset_an", an_o, 8'hFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
